// File: rtl/fetch_stage_pipe.sv
// fetch_stage_pipe: PC register, instruction capture into IF/ID, branch flush, freeze and fetch counting
module fetch_stage_pipe #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] NOP_WORD = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  input  logic [31:0] instruction_in,
  output logic [31:0] pc_address,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);
  logic [31:0] pc;
  logic [31:0] pc_next;
  assign pc_address = pc;
  assign pc_next = pc + 32'd4;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= {RESET_PC[31:2], 2'b00};
      if_id_pc <= '0;
      if_id_instruction <= NOP_WORD;
      if_id_valid <= 1'b0;
      fetch_count <= '0;
    end else if (branch_taken) begin
      pc <= {branch_address[31:2], 2'b00};
      if_id_pc <= '0;
      if_id_instruction <= NOP_WORD;
      if_id_valid <= 1'b0;
    end else if (!freeze) begin
      pc <= pc_next;
      if_id_pc <= pc_next;
      if_id_instruction <= instruction_in;
      if_id_valid <= 1'b1;
      fetch_count <= fetch_count + {31'd0, fetch_count != '1};
    end
  end
endmodule

// File: tb/tb_fetch_stage_pipe.sv
// tb_fetch_stage_pipe: directed steps push expected IF state; a negedge monitor pops and compares
module tb_fetch_stage_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_address = '0;
  logic [31:0] instruction_in;
  logic [31:0] pc_address, if_id_pc, if_id_instruction, fetch_count;
  logic        if_id_valid;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] ins;
    logic        v;
    logic [31:0] cnt;
  } exp_t;
  exp_t sb[$];

  fetch_stage_pipe dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_address(branch_address), .instruction_in(instruction_in),
    .pc_address(pc_address), .if_id_pc(if_id_pc), .if_id_instruction(if_id_instruction),
    .if_id_valid(if_id_valid), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h8001060A;
      32'd4:   return 32'h20420005;
      32'd8:   return 32'h00221820;
      32'd12:  return 32'h04011000;
      default: return {~a[15:0], a[15:0]};
    endcase
  endfunction

  assign instruction_in = mem(pc_address);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".pc_address"}, pc_address, e.pc);
      check({e.name, ".if_id_pc"}, if_id_pc, e.ifpc);
      check({e.name, ".if_id_instruction"}, if_id_instruction, e.ins);
      check({e.name, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, e.v});
      check({e.name, ".fetch_count"}, fetch_count, e.cnt);
    end
  end

  task automatic step(input string name, input logic r, input logic b, input logic [31:0] ba,
                      input logic f, input logic [31:0] pc, input logic [31:0] ifpc,
                      input logic [31:0] ins, input logic v, input logic [31:0] cnt,
                      input logic preload = 1'b0);
    exp_t e;
    @(negedge clk);
    rst = r;
    branch_taken = b;
    branch_address = ba;
    freeze = f;
    if (preload) begin
      #2;
      dut.fetch_count = 32'hFFFFFFFE;
    end
    @(posedge clk);
    e.name = name; e.pc = pc; e.ifpc = ifpc; e.ins = ins; e.v = v; e.cnt = cnt;
    sb.push_back(e);
  endtask

  initial begin
    step("reset",      1, 0, 32'h0,        0, 32'd0,   32'd0,   32'h0,        0, 32'd0);
    step("adv0",       0, 0, 32'h0,        0, 32'd4,   32'd4,   32'h8001060A, 1, 32'd1);
    step("adv4",       0, 0, 32'h0,        0, 32'd8,   32'd8,   32'h20420005, 1, 32'd2);
    step("adv8",       0, 0, 32'h0,        0, 32'd12,  32'd12,  32'h00221820, 1, 32'd3);
    step("frz1",       0, 0, 32'h0,        1, 32'd12,  32'd12,  32'h00221820, 1, 32'd3);
    step("frz2",       0, 0, 32'h0,        1, 32'd12,  32'd12,  32'h00221820, 1, 32'd3);
    step("frz3",       0, 0, 32'h0,        1, 32'd12,  32'd12,  32'h00221820, 1, 32'd3);
    step("release",    0, 0, 32'h0,        0, 32'd16,  32'd16,  32'h04011000, 1, 32'd4);
    step("br312",      0, 1, 32'd312,      0, 32'd312, 32'd0,   32'h0,        0, 32'd4);
    step("br_frz_cf",  0, 1, 32'h000000CF, 1, 32'd204, 32'd0,   32'h0,        0, 32'd4);
    step("adv204",     0, 0, 32'h0,        0, 32'd208, 32'd208, mem(32'd204), 1, 32'd5);
    step("br100",      0, 1, 32'd100,      0, 32'd100, 32'd0,   32'h0,        0, 32'd5);
    step("rst_br",     1, 1, 32'd500,      1, 32'd0,   32'd0,   32'h0,        0, 32'd0);
    step("adv_again",  0, 0, 32'h0,        0, 32'd4,   32'd4,   32'h8001060A, 1, 32'd1);
    step("br_top",     0, 1, 32'hFFFFFFFF, 0, 32'hFFFFFFFC, 32'd0, 32'h0,     0, 32'd1);
    step("wrap",       0, 0, 32'h0,        0, 32'd0,   32'd0,   mem(32'hFFFFFFFC), 1, 32'd2);
    step("br_seq1",    0, 1, 32'h40,       0, 32'h40,  32'd0,   32'h0,        0, 32'd2);
    step("br_seq2",    0, 1, 32'h80,       0, 32'h80,  32'd0,   32'h0,        0, 32'd2);
    step("br392",      0, 1, 32'd392,      0, 32'd392, 32'd0,   32'h0,        0, 32'd2);
    step("loop_a1",    0, 0, 32'h0,        0, 32'd396, 32'd396, mem(32'd392), 1, 32'd3);
    step("loop_b1",    0, 1, 32'd392,      0, 32'd392, 32'd0,   32'h0,        0, 32'd3);
    step("loop_a2",    0, 0, 32'h0,        0, 32'd396, 32'd396, mem(32'd392), 1, 32'd4);
    step("loop_b2",    0, 1, 32'd392,      1, 32'd392, 32'd0,   32'h0,        0, 32'd4);
    step("sat_hit",    0, 0, 32'h0,        0, 32'd396, 32'd396, mem(32'd392), 1, 32'hFFFFFFFF, 1'b1);
    step("sat_hold",   0, 0, 32'h0,        0, 32'd400, 32'd400, mem(32'd396), 1, 32'hFFFFFFFF);
    step("sat_frz",    0, 0, 32'h0,        1, 32'd400, 32'd400, mem(32'd396), 1, 32'hFFFFFFFF);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "timeout");
  end
endmodule
